// File: rtl/tile_frame_buffer_pkg.sv
// Shared state encoding and width helpers for the tile frame buffer.
package tile_frame_buffer_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      COMMIT_INIT = 2'd1,
      COMMIT      = 2'd2,
      MEMSET      = 2'd3
   } bufferState_t;

   // Width of a counter that walks 0..count-1; never narrower than one bit.
   function automatic int countWidth(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/tile_frame_buffer_ram.sv
// Simple dual-port block RAM: one masked write port, one registered read port.
module DualPortRam #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int LANE_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             writeEnable,
   input  logic [ADDR_WIDTH-1:0]            writeAddr,
   input  logic [DATA_WIDTH-1:0]            writeData,
   input  logic [DATA_WIDTH/LANE_WIDTH-1:0] writeMask,
   input  logic [ADDR_WIDTH-1:0]            readAddr,
   output logic [DATA_WIDTH-1:0]            readData
);
   localparam int LANES = DATA_WIDTH/LANE_WIDTH;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // NOTE: the array has no reset; clearing it would stop it mapping onto block RAM.
   always_ff @(posedge clk) begin
      for (int lane = 0; lane < LANES; lane++) begin
         if (writeEnable && writeMask[lane]) begin
            mem[writeAddr][lane*LANE_WIDTH +: LANE_WIDTH] <= writeData[lane*LANE_WIDTH +: LANE_WIDTH];
         end
      end
      readData <= mem[readAddr];
   end

endmodule

// File: rtl/tile_frame_buffer_strobe.sv
// Per-slot memset strobe: channel clear mask gated by the scissor rectangle.
module memset_strobe_gen #(
   parameter int NUMBER_OF_SUB_PIXELS = 4,
   parameter int PIXEL_PER_BEAT       = 1,
   parameter int X_WIDTH              = 8,
   parameter int Y_WIDTH              = 8,
   parameter int BEAT_X_WIDTH         = 7,
   parameter int LINE_WIDTH           = 7
) (
   input  logic [BEAT_X_WIDTH-1:0]                         beatX,
   input  logic [LINE_WIDTH-1:0]                           beatY,
   input  logic [NUMBER_OF_SUB_PIXELS-1:0]                 clearMask,
   input  logic                                            scissorEnable,
   input  logic [X_WIDTH-1:0]                              startX,
   input  logic [X_WIDTH-1:0]                              endX,
   input  logic [Y_WIDTH-1:0]                              startY,
   input  logic [Y_WIDTH-1:0]                              endY,
   output logic [NUMBER_OF_SUB_PIXELS*PIXEL_PER_BEAT-1:0]  strobe
);
   logic                lineInside;
   logic [X_WIDTH-1:0]  pixelX;

   assign lineInside = (Y_WIDTH'(beatY) >= startY) && (Y_WIDTH'(beatY) < endY);

   // An empty rectangle (start >= end) simply never matches, so nothing is written.
   always_comb begin
      strobe = '0;
      pixelX = '0;
      for (int s = 0; s < PIXEL_PER_BEAT; s++) begin
         pixelX = X_WIDTH'(beatX) * X_WIDTH'(PIXEL_PER_BEAT) + X_WIDTH'(s);
         if (!scissorEnable || (lineInside && (pixelX >= startX) && (pixelX < endX))) begin
            strobe[s*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] = clearMask;
         end
      end
   end

endmodule

// File: rtl/tile_frame_buffer.sv
// Tile/frame buffer: fragment read/write port plus AXIS commit and scissored memset commands.
module tile_frame_buffer
   import tile_frame_buffer_pkg::*;
#(
   parameter int X_RESOLUTION         = 128,
   parameter int Y_RESOLUTION         = 128,
   parameter int NUMBER_OF_SUB_PIXELS = 4,
   parameter int SUB_PIXEL_WIDTH      = 4,
   parameter int STREAM_WIDTH         = 16,
   localparam int PIXEL_WIDTH         = NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH,
   localparam int PIXEL_PER_BEAT      = STREAM_WIDTH/PIXEL_WIDTH,
   localparam int BEATS_PER_LINE      = X_RESOLUTION/PIXEL_PER_BEAT,
   localparam int ADDR_WIDTH          = $clog2(X_RESOLUTION*Y_RESOLUTION),
   localparam int X_WIDTH             = $clog2(X_RESOLUTION)+1,
   localparam int Y_WIDTH             = $clog2(Y_RESOLUTION)+1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [ADDR_WIDTH-1:0]            fragIndexRead,
   output logic [PIXEL_WIDTH-1:0]           fragOut,
   input  logic [ADDR_WIDTH-1:0]            fragIndexWrite,
   input  logic [PIXEL_WIDTH-1:0]           fragIn,
   input  logic                             fragWriteEnable,
   input  logic [NUMBER_OF_SUB_PIXELS-1:0]  fragMask,
   input  logic                             apply,
   output logic                             applied,
   input  logic                             cmdCommit,
   input  logic                             cmdMemset,
   input  logic [PIXEL_WIDTH-1:0]           clearColor,
   input  logic [NUMBER_OF_SUB_PIXELS-1:0]  clearMask,
   input  logic                             scissorEnable,
   input  logic [X_WIDTH-1:0]               scissorStartX,
   input  logic [X_WIDTH-1:0]               scissorEndX,
   input  logic [Y_WIDTH-1:0]               scissorStartY,
   input  logic [Y_WIDTH-1:0]               scissorEndY,
   input  logic                             lineLast,
   output logic                             m_axis_tvalid,
   input  logic                             m_axis_tready,
   output logic                             m_axis_tlast,
   output logic [STREAM_WIDTH-1:0]          m_axis_tdata
);
   localparam int SLOT_BITS       = $clog2(PIXEL_PER_BEAT);
   localparam int SLOT_WIDTH      = countWidth(PIXEL_PER_BEAT);
   localparam int BEAT_ADDR_WIDTH = ADDR_WIDTH - SLOT_BITS;
   localparam int NUM_BEATS       = BEATS_PER_LINE*Y_RESOLUTION;
   localparam int BEAT_X_WIDTH    = countWidth(BEATS_PER_LINE);
   localparam int LINE_WIDTH      = countWidth(Y_RESOLUTION);
   localparam int LANES           = NUMBER_OF_SUB_PIXELS*PIXEL_PER_BEAT;

   localparam logic [SLOT_WIDTH-1:0]      SLOT_MASK   = SLOT_WIDTH'(PIXEL_PER_BEAT-1);
   localparam logic [BEAT_ADDR_WIDTH-1:0] LAST_BEAT   = BEAT_ADDR_WIDTH'(NUM_BEATS-1);
   localparam logic [BEAT_X_WIDTH-1:0]    LAST_BEAT_X = BEAT_X_WIDTH'(BEATS_PER_LINE-1);

   bufferState_t state;

   logic [PIXEL_WIDTH-1:0]          clearColorQ;
   logic [NUMBER_OF_SUB_PIXELS-1:0] clearMaskQ;
   logic                            scissorEnableQ;
   logic [X_WIDTH-1:0]              startXQ, endXQ;
   logic [Y_WIDTH-1:0]              startYQ, endYQ;
   logic                            lineLastQ;
   logic                            memsetQ;

   logic [BEAT_ADDR_WIDTH-1:0]      readAddr;
   logic [BEAT_X_WIDTH-1:0]         readX;
   logic                            allIssued;
   logic                            rdPending;
   logic                            rdLast;
   logic                            skValid;
   logic                            skLast;
   logic [STREAM_WIDTH-1:0]         skData;

   logic [BEAT_ADDR_WIDTH-1:0]      memAddr;
   logic [BEAT_X_WIDTH-1:0]         memX;
   logic [LINE_WIDTH-1:0]           memY;
   logic [LANES-1:0]                memsetStrobe;

   logic [SLOT_WIDTH-1:0]           writeSlot;
   logic [SLOT_WIDTH-1:0]           readSlotQ;
   logic [LANES-1:0]                fragStrobe;

   logic                            ramWriteEnable;
   logic [BEAT_ADDR_WIDTH-1:0]      ramWriteAddr;
   logic [STREAM_WIDTH-1:0]         ramWriteData;
   logic [LANES-1:0]                ramWriteMask;
   logic [BEAT_ADDR_WIDTH-1:0]      ramReadAddr;
   logic [STREAM_WIDTH-1:0]         ramReadData;

   logic                            pop;
   logic [1:0]                      occupancy;
   logic                            issueRead;
   logic                            issueLast;
   logic                            finalPop;

   // Fragment write strobe: fragMask placed into the addressed pixel slot only.
   assign writeSlot = SLOT_WIDTH'(fragIndexWrite) & SLOT_MASK;

   always_comb begin
      fragStrobe = '0;
      for (int s = 0; s < PIXEL_PER_BEAT; s++) begin
         if (writeSlot == SLOT_WIDTH'(s)) begin
            fragStrobe[s*NUMBER_OF_SUB_PIXELS +: NUMBER_OF_SUB_PIXELS] = fragMask;
         end
      end
   end

   memset_strobe_gen #(
      .NUMBER_OF_SUB_PIXELS (NUMBER_OF_SUB_PIXELS),
      .PIXEL_PER_BEAT       (PIXEL_PER_BEAT),
      .X_WIDTH              (X_WIDTH),
      .Y_WIDTH              (Y_WIDTH),
      .BEAT_X_WIDTH         (BEAT_X_WIDTH),
      .LINE_WIDTH           (LINE_WIDTH)
   ) strobeGen (
      .beatX         (memX),
      .beatY         (memY),
      .clearMask     (clearMaskQ),
      .scissorEnable (scissorEnableQ),
      .startX        (startXQ),
      .endX          (endXQ),
      .startY        (startYQ),
      .endY          (endYQ),
      .strobe        (memsetStrobe)
   );

   // The write port belongs to the fragment path in IDLE and to memset in MEMSET.
   always_comb begin
      ramWriteEnable = 1'b0;
      ramWriteAddr   = fragIndexWrite[ADDR_WIDTH-1:SLOT_BITS];
      ramWriteData   = {PIXEL_PER_BEAT{fragIn}};
      ramWriteMask   = fragStrobe;
      if (state == IDLE) begin
         ramWriteEnable = fragWriteEnable;
      end else if (state == MEMSET) begin
         ramWriteEnable = 1'b1;
         ramWriteAddr   = memAddr;
         ramWriteData   = {PIXEL_PER_BEAT{clearColorQ}};
         ramWriteMask   = memsetStrobe;
      end
   end

   assign ramReadAddr = (state == IDLE) ? fragIndexRead[ADDR_WIDTH-1:SLOT_BITS] : readAddr;

   DualPortRam #(
      .ADDR_WIDTH (BEAT_ADDR_WIDTH),
      .DATA_WIDTH (STREAM_WIDTH),
      .LANE_WIDTH (SUB_PIXEL_WIDTH)
   ) frameRam (
      .clk         (clk),
      .writeEnable (ramWriteEnable),
      .writeAddr   (ramWriteAddr),
      .writeData   (ramWriteData),
      .writeMask   (ramWriteMask),
      .readAddr    (ramReadAddr),
      .readData    (ramReadData)
   );

   assign fragOut = ramReadData[int'(readSlotQ)*PIXEL_WIDTH +: PIXEL_WIDTH];

   // Output register + skid register + in-flight RAM read must never exceed two beats,
   // so a read is issued only when at most one beat would remain after this cycle.
   assign pop       = m_axis_tvalid && m_axis_tready;
   assign occupancy = 2'(m_axis_tvalid) + 2'(skValid) + 2'(rdPending) - 2'(pop);
   assign issueRead = ((state == COMMIT_INIT) || (state == COMMIT)) && !allIssued && (occupancy <= 2'd1);
   assign issueLast = lineLastQ ? (readX == LAST_BEAT_X) : (readAddr == LAST_BEAT);
   assign finalPop  = pop && !skValid && !rdPending && allIssued;

   always_ff @(posedge clk) begin
      readSlotQ <= SLOT_WIDTH'(fragIndexRead) & SLOT_MASK;
      if (reset) begin
         state         <= IDLE;
         applied       <= 1'b1;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         skValid       <= 1'b0;
         rdPending     <= 1'b0;
         allIssued     <= 1'b0;
         readAddr      <= '0;
         readX         <= '0;
         memAddr       <= '0;
         memX          <= '0;
         memY          <= '0;
      end else begin
         rdPending <= issueRead;
         if (issueRead) begin
            rdLast    <= issueLast;
            readAddr  <= readAddr + 1;
            readX     <= (readX == LAST_BEAT_X) ? '0 : readX + 1;
            allIssued <= (readAddr == LAST_BEAT);
         end

         // Output stage only reloads when empty or handshaking, keeping tdata/tlast stable under stall.
         if (pop || !m_axis_tvalid) begin
            if (skValid) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= skData;
               m_axis_tlast  <= skLast;
               skValid       <= rdPending;
               skData        <= ramReadData;
               skLast        <= rdLast;
            end else if (rdPending) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= ramReadData;
               m_axis_tlast  <= rdLast;
            end else begin
               m_axis_tvalid <= 1'b0;
               m_axis_tlast  <= 1'b0;
            end
         end else if (rdPending) begin
            skValid <= 1'b1;
            skData  <= ramReadData;
            skLast  <= rdLast;
         end

         if (state != MEMSET) begin
            memAddr <= '0;
            memX    <= '0;
            memY    <= '0;
         end

         case (state)
            IDLE: begin
               readAddr  <= '0;
               readX     <= '0;
               allIssued <= 1'b0;
               if (apply) begin
                  clearColorQ    <= clearColor;
                  clearMaskQ     <= clearMask;
                  scissorEnableQ <= scissorEnable;
                  startXQ        <= scissorStartX;
                  endXQ          <= scissorEndX;
                  startYQ        <= scissorStartY;
                  endYQ          <= scissorEndY;
                  lineLastQ      <= lineLast;
                  memsetQ        <= cmdMemset;
                  if (cmdCommit) begin
                     state   <= COMMIT_INIT;
                     applied <= 1'b0;
                  end else if (cmdMemset) begin
                     state   <= MEMSET;
                     applied <= 1'b0;
                  end
               end
            end
            COMMIT_INIT: begin
               state <= COMMIT;
            end
            COMMIT: begin
               if (finalPop) begin
                  if (memsetQ) begin
                     state <= MEMSET;
                  end else begin
                     state   <= IDLE;
                     applied <= 1'b1;
                  end
               end
            end
            MEMSET: begin
               memAddr <= memAddr + 1;
               if (memX == LAST_BEAT_X) begin
                  memX <= '0;
                  memY <= memY + 1;
               end else begin
                  memX <= memX + 1;
               end
               if (memAddr == LAST_BEAT) begin
                  state   <= IDLE;
                  applied <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               applied <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_frame_buffer.sv
// Directed bench for tile_frame_buffer: 8x4 frame, 2x4-bit channels, 4 pixels per 32-bit beat.
module tb_tile_frame_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  fragIndexRead;
   logic [7:0]  fragOut;
   logic [4:0]  fragIndexWrite;
   logic [7:0]  fragIn;
   logic        fragWriteEnable;
   logic [1:0]  fragMask;
   logic        apply;
   logic        applied;
   logic        cmdCommit;
   logic        cmdMemset;
   logic [7:0]  clearColor;
   logic [1:0]  clearMask;
   logic        scissorEnable;
   logic [3:0]  scissorStartX, scissorEndX;
   logic [2:0]  scissorStartY, scissorEndY;
   logic        lineLast;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [31:0] m_axis_tdata;

   int checkCount = 0;
   int passCount  = 0;

   logic [31:0] gotData [16];
   logic        gotLast [16];
   int          gotCount;
   logic [15:0] readyPattern = 16'b1011_0010_0111_0100;

   logic [31:0] scissorBeats [8] = '{32'h3C3C3C3C, 32'h3C3C3C3C, 32'hFFFF3C3C, 32'h3C3CFFFF,
                                     32'hFFFF3C3C, 32'h3C3CFFFF, 32'h3C3C3C3C, 32'h3C3C3C3C};

   tile_frame_buffer #(
      .X_RESOLUTION         (8),
      .Y_RESOLUTION         (4),
      .NUMBER_OF_SUB_PIXELS (2),
      .SUB_PIXEL_WIDTH      (4),
      .STREAM_WIDTH         (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fragIndexRead   (fragIndexRead),
      .fragOut         (fragOut),
      .fragIndexWrite  (fragIndexWrite),
      .fragIn          (fragIn),
      .fragWriteEnable (fragWriteEnable),
      .fragMask        (fragMask),
      .apply           (apply),
      .applied         (applied),
      .cmdCommit       (cmdCommit),
      .cmdMemset       (cmdMemset),
      .clearColor      (clearColor),
      .clearMask       (clearMask),
      .scissorEnable   (scissorEnable),
      .scissorStartX   (scissorStartX),
      .scissorEndX     (scissorEndX),
      .scissorStartY   (scissorStartY),
      .scissorEndY     (scissorEndY),
      .lineLast        (lineLast),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tdata    (m_axis_tdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fragWrite(input logic [4:0] idx, input logic [7:0] data, input logic [1:0] mask);
      fragIndexWrite  = idx;
      fragIn          = data;
      fragMask        = mask;
      fragWriteEnable = 1'b1;
      tick();
      fragWriteEnable = 1'b0;
   endtask

   task automatic fragRead(input logic [4:0] idx, output logic [7:0] data);
      fragIndexRead = idx;
      tick();
      data = fragOut;
   endtask

   // Command inputs are scrambled right after apply, so only latched values may matter.
   task automatic runCommand(input bit commit, input bit memset, input logic [7:0] color,
                             input logic [1:0] mask, input bit scEn,
                             input logic [3:0] sx, input logic [3:0] ex,
                             input logic [2:0] sy, input logic [2:0] ey, input bit ll);
      cmdCommit     = commit;
      cmdMemset     = memset;
      clearColor    = color;
      clearMask     = mask;
      scissorEnable = scEn;
      scissorStartX = sx;
      scissorEndX   = ex;
      scissorStartY = sy;
      scissorEndY   = ey;
      lineLast      = ll;
      apply         = 1'b1;
      tick();
      apply         = 1'b0;
      cmdCommit     = 1'b0;
      cmdMemset     = 1'b0;
      clearColor    = ~color;
      clearMask     = ~mask;
      scissorEnable = ~scEn;
      scissorStartX = 4'd0;
      scissorEndX   = 4'd0;
      scissorStartY = 3'd0;
      scissorEndY   = 3'd0;
      lineLast      = ~ll;
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (!applied && n < 100) begin
         tick();
         n++;
      end
      check(tag, 32'(applied), 32'd1);
   endtask

   task automatic memsetFull(input logic [7:0] color, input logic [1:0] mask);
      runCommand(1'b0, 1'b1, color, mask, 1'b0, 4'd0, 4'd8, 3'd0, 3'd4, 1'b0);
      waitIdle("memset done");
   endtask

   // Records every beat that handshakes; with randomReady, also checks that stalled beats hold.
   task automatic collectCommit(input bit randomReady);
      logic [31:0] prevData;
      logic        prevLast;
      bit          prevStall = 1'b0;
      gotCount = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         m_axis_tready = randomReady ? readyPattern[cyc % 16] : 1'b1;
         if (prevStall) begin
            check("stall valid", 32'(m_axis_tvalid), 32'd1);
            check("stall data", m_axis_tdata, prevData);
            check("stall last", 32'(m_axis_tlast), 32'(prevLast));
         end
         prevStall = m_axis_tvalid && !m_axis_tready;
         prevData  = m_axis_tdata;
         prevLast  = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready && gotCount < 16) begin
            gotData[gotCount] = m_axis_tdata;
            gotLast[gotCount] = m_axis_tlast;
            gotCount++;
         end
         tick();
         if (gotCount == 8) begin
            check("tvalid drop", 32'(m_axis_tvalid), 32'd0);
            break;
         end
      end
      m_axis_tready = 1'b0;
      check("beat count", 32'(gotCount), 32'd8);
   endtask

   function automatic logic [31:0] patternBeat(input int b);
      logic [31:0] w;
      for (int s = 0; s < 4; s++) w[s*8 +: 8] = 8'(8'h40 + 4*b + s);
      return w;
   endfunction

   initial begin
      logic [7:0] px;
      int dur;
      int hs;

      reset = 1'b1;  apply = 1'b0;  cmdCommit = 1'b0;  cmdMemset = 1'b0;
      fragIndexRead = '0;  fragIndexWrite = '0;  fragIn = '0;  fragWriteEnable = 1'b0;
      fragMask = '0;  clearColor = '0;  clearMask = '0;  scissorEnable = 1'b0;
      scissorStartX = '0;  scissorEndX = '0;  scissorStartY = '0;  scissorEndY = '0;
      lineLast = 1'b0;  m_axis_tready = 1'b0;
      repeat (3) tick();
      check("reset applied", 32'(applied), 32'd1);
      check("reset tvalid", 32'(m_axis_tvalid), 32'd0);
      check("reset tlast", 32'(m_axis_tlast), 32'd0);
      reset = 1'b0;
      tick();

      memsetFull(8'h00, 2'b11);

      // Apply with neither command stays idle.
      runCommand(1'b0, 1'b0, 8'h11, 2'b11, 1'b0, 4'd0, 4'd8, 3'd0, 3'd4, 1'b0);
      check("no-op applied", 32'(applied), 32'd1);

      // Fragment path.
      fragWrite(5'd5, 8'hA5, 2'b11);
      fragRead(5'd5, px);  check("frag idx5", 32'(px), 32'hA5);
      fragRead(5'd4, px);  check("frag idx4", 32'(px), 32'h00);
      fragRead(5'd6, px);  check("frag idx6", 32'(px), 32'h00);
      fragWrite(5'd6, 8'hC3, 2'b10);
      fragRead(5'd6, px);  check("frag mask10", 32'(px), 32'hC0);

      // Full memset then commit.
      memsetFull(8'h3C, 2'b11);
      runCommand(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      check("commit busy", 32'(applied), 32'd0);
      collectCommit(1'b0);
      for (int b = 0; b < 8; b++) begin
         check($sformatf("fill data%0d", b), gotData[b], 32'h3C3C3C3C);
         check($sformatf("fill last%0d", b), 32'(gotLast[b]), 32'(b == 7));
      end
      waitIdle("commit done");

      // Scissored memset, read back through commit.
      runCommand(1'b0, 1'b1, 8'hFF, 2'b11, 1'b1, 4'd2, 4'd6, 3'd1, 3'd3, 1'b0);
      waitIdle("scissor done");
      runCommand(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      collectCommit(1'b0);
      for (int b = 0; b < 8; b++) check($sformatf("scissor beat%0d", b), gotData[b], scissorBeats[b]);
      waitIdle("commit done");

      // Channel-masked memset over a zero frame.
      memsetFull(8'h00, 2'b11);
      memsetFull(8'h7E, 2'b01);
      fragRead(5'd0,  px);  check("chmask px0", 32'(px), 32'h0E);
      fragRead(5'd13, px);  check("chmask px13", 32'(px), 32'h0E);
      fragRead(5'd31, px);  check("chmask px31", 32'(px), 32'h0E);

      // Empty rectangle: full duration, no writes; a fragment write while busy is dropped.
      runCommand(1'b0, 1'b1, 8'hFF, 2'b11, 1'b1, 4'd5, 4'd5, 3'd0, 3'd4, 1'b0);
      fragIndexWrite = 5'd0;  fragIn = 8'h99;  fragMask = 2'b11;  fragWriteEnable = 1'b1;
      dur = 0;
      while (!applied && dur < 50) begin
         dur++;
         tick();
         fragWriteEnable = 1'b0;
      end
      fragWriteEnable = 1'b0;
      check("empty duration", 32'(dur), 32'd8);
      fragRead(5'd0,  px);  check("busy write drop", 32'(px), 32'h0E);
      fragRead(5'd21, px);  check("empty rect px21", 32'(px), 32'h0E);

      // Back-pressure with per-line tlast.
      for (int i = 0; i < 32; i++) fragWrite(5'(i), 8'(8'h40 + i), 2'b11);
      runCommand(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b1);
      collectCommit(1'b1);
      for (int b = 0; b < 8; b++) begin
         check($sformatf("bp data%0d", b), gotData[b], patternBeat(b));
         check($sformatf("bp last%0d", b), 32'(gotLast[b]), 32'(b % 2 == 1));
      end
      waitIdle("bp done");

      // Commit + memset: the stream carries the pre-clear frame.
      runCommand(1'b1, 1'b1, 8'h00, 2'b11, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      collectCommit(1'b0);
      check("cm memset busy", 32'(applied), 32'd0);
      for (int b = 0; b < 8; b++) begin
         check($sformatf("cm data%0d", b), gotData[b], patternBeat(b));
         check($sformatf("cm last%0d", b), 32'(gotLast[b]), 32'(b == 7));
      end
      waitIdle("cm done");
      fragRead(5'd0,  px);  check("cm clear px0", 32'(px), 32'h00);
      fragRead(5'd17, px);  check("cm clear px17", 32'(px), 32'h00);
      fragRead(5'd31, px);  check("cm clear px31", 32'(px), 32'h00);

      // Reset while beat 3 of a commit is on the bus.
      runCommand(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0, 1'b0);
      m_axis_tready = 1'b1;
      hs = 0;
      for (int n = 0; n < 100; n++) begin
         if (m_axis_tvalid && hs == 2) break;
         if (m_axis_tvalid && m_axis_tready) hs++;
         tick();
      end
      check("reset reach beat3", 32'(hs), 32'd2);
      reset = 1'b1;
      tick();
      check("midreset tvalid", 32'(m_axis_tvalid), 32'd0);
      check("midreset applied", 32'(applied), 32'd1);
      reset = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      fragRead(5'd9, px);  check("post-reset read", 32'(px), 32'h00);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/tile_frame_buffer.md
Name: tile_frame_buffer

Overview:
Second-generation on-chip tile/frame buffer for the rasterizer back end. It stores a resolution-parametrised frame in block RAM and gives the pixel pipeline single-fragment read and write access. It also runs two commands, commit and memset, both executed via an apply/applied handshake. New in this generation:
- X/Y-aware memset restricted to a scissor rectangle.
- Per-channel clear mask.
- Fully back-pressure-safe AXIS commit stream with per-line tlast option.

Parameters:
- X_RESOLUTION, 128, frame width in pixels; must be a multiple of PIXEL_PER_BEAT.
- Y_RESOLUTION, 128, frame height in lines.
- NUMBER_OF_SUB_PIXELS, 4, channels per pixel; one write-strobe bit per channel.
- SUB_PIXEL_WIDTH, 4, bits per channel.
- STREAM_WIDTH, 16, RAM word and AXIS width; must be a power-of-two multiple of PIXEL_WIDTH.
- Derived (localparam):
  - PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH
  - PIXEL_PER_BEAT = STREAM_WIDTH/PIXEL_WIDTH
  - BEATS_PER_LINE = X_RESOLUTION/PIXEL_PER_BEAT
  - ADDR_WIDTH = clog2(X_RESOLUTION*Y_RESOLUTION)

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fragIndexRead  in  ADDR_WIDTH  linear pixel index to read (y*X_RESOLUTION+x).
- fragOut  out  PIXEL_WIDTH  read data, valid 1 cycle after fragIndexRead.
- fragIndexWrite  in  ADDR_WIDTH  linear pixel index to write.
- fragIn  in  PIXEL_WIDTH  write data.
- fragWriteEnable  in  1  write strobe.
- fragMask  in  NUMBER_OF_SUB_PIXELS  per-channel write enable for fragment writes.
- apply  in  1  start command; command inputs are sampled this cycle.
- applied  out  1  1 = idle/done, 0 = command executing.
- cmdCommit  in  1  stream the frame out on AXIS.
- cmdMemset  in  1  fill with clearColor.
- clearColor  in  PIXEL_WIDTH  memset value.
- clearMask  in  NUMBER_OF_SUB_PIXELS  per-channel memset enable.
- scissorEnable  in  1  restrict memset to the scissor rectangle.
- scissorStartX, scissorEndX  in  clog2(X_RESOLUTION)+1  inclusive start / exclusive end column.
- scissorStartY, scissorEndY  in  clog2(Y_RESOLUTION)+1  inclusive start / exclusive end line.
- lineLast  in  1  1 = tlast on the last beat of every line; 0 = only on the final beat of the frame.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tlast  out  1  AXIS last.
- m_axis_tdata  out  STREAM_WIDTH  AXIS data; pixel 0 in the LSBs.

Behaviour:
- Reset values: applied=1, m_axis_tvalid=0, m_axis_tlast=0, state=IDLE. RAM contents are not cleared.
- Reset mid-command: the next cycle is IDLE with tvalid=0. A partial memset is left as is.
- Fragment reads: 1-cycle latency; correct sub-word selected via the delayed low index bits.
- Fragment writes:
  - Word strobe = fragMask replicated into the slot given by fragIndexWrite[log2 PIXEL_PER_BEAT-1:0]; all other slots 0.
  - Honoured only in IDLE. A write in the same cycle as apply is performed.
  - Writes while applied=0 are dropped; reads while applied=0 return undefined data.
- Command inputs (clearColor, clearMask, scissor fields, lineLast, cmdMemset) are latched on apply. Later changes do not affect the running command.
- States:
  - IDLE → COMMIT_INIT if cmdCommit; → MEMSET if only cmdMemset; apply with neither keeps applied=1.
  - COMMIT_INIT: issue read of beat 0 → COMMIT.
  - COMMIT → MEMSET if memset was latched, else → IDLE.
  - MEMSET → IDLE.
  - applied drops to 0 the cycle after apply and returns to 1 on entry to IDLE.
- Commit:
  - Beats are streamed in order, line-major, BEATS_PER_LINE*Y_RESOLUTION beats.
  - tdata/tlast stay stable while tvalid && !tready (1-entry skid register behind the RAM read).
  - No beat is lost or duplicated under any tready pattern.
  - tvalid deasserts the cycle after the final handshake.
- Memset:
  - One beat per cycle, no back-pressure, BEATS_PER_LINE*Y_RESOLUTION cycles.
  - Per-pixel strobe = clearMask AND (scissorEnable==0 OR (startX<=x<endX AND startY<=y<endY)), where x is the pixel column of each slot.
  - Beat x/y are tracked with separate counters, not by division.
  - Empty rectangle (start>=end): no writes, but full duration.
- Commit then memset: memset starts the cycle after the final handshake, so committed data is the pre-clear frame.

Decomposition:
- Package tile_frame_buffer_pkg: state encoding (IDLE, COMMIT_INIT, COMMIT, MEMSET) and derived-width functions.
- RAM: existing DualPortRam (1 write port with byte-lane mask at SUB_PIXEL_WIDTH granularity, 1 read port, 1-cycle read).
- Sub-module memset_strobe_gen: combinational per-slot scissor/mask strobe from beat x/y and the latched rectangle.

Test Plan:
Configuration for all scenarios: X=8, Y=4, STREAM_WIDTH=32, 2x 4-bit channels, PIXEL_WIDTH=8, so 4 px/beat, 8 beats.
1. Fragment path: write index 5 = 0xA5 with mask 11 → read index 5 returns 0xA5 one cycle later; neighbours at index 4 and 6 are unchanged.
2. Memset then commit: memset 0x3C, full, no scissor; then commit with tready=1 → 8 beats of 0x3C3C3C3C, tlast only on beat 8, applied returns to 1.
3. Scissor memset: memset 0xFF with X 2..6, Y 1..3 → lines 1–2 hold 0xFF at x=2..5; all other pixels unchanged.
4. Channel mask: clearMask=01, clearColor=0x7E over 0x00 → every pixel reads 0x0E.
5. Back-pressure: commit with tready toggling pseudo-randomly, lineLast=1 → 8 unique beats in order, tlast on beats 2,4,6,8, tdata stable while stalled.
6. Combined command and reset: commit+memset 0x00 on a known pattern → streamed data is the old pattern, then all zero. Separately, assert reset in beat 3 of a commit → tvalid=0 and applied=1 on the next cycle.
